// File: rtl/axi_word_writer.sv
// axi_word_writer: pops 128-bit packed words from the word FIFO and issues each
// one as a single-beat AXI4 write. Addresses increment by one word and wrap
// inside a fixed region. Also counts completed writes and error responses.
module axi_word_writer #(
  parameter int                    DATA_WIDTH   = 128,
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
  parameter int                    REGION_WORDS = 65536
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      word_fifo_empty,
  input  logic [DATA_WIDTH-1:0]     word_fifo_dout,
  output logic                      word_fifo_rd_en,
  output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [7:0]                m_axi_awlen,
  output logic [2:0]                m_axi_awsize,
  output logic [1:0]                m_axi_awburst,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                      m_axi_wlast,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  input  logic [1:0]                m_axi_bresp,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready,
  output logic                      busy,
  output logic [31:0]               wr_count,
  output logic [15:0]               err_count
);

  localparam int IDX_W = (REGION_WORDS > 1) ? $clog2(REGION_WORDS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(REGION_WORDS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] XFER = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0]            state_q, state_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [31:0]           wr_count_q, wr_count_d;
  logic [15:0]           err_count_q, err_count_d;

  // Fixed single-beat, full-width INCR tie-offs.
  assign m_axi_awlen   = 8'd0;
  assign m_axi_awsize  = 3'b100;
  assign m_axi_awburst = 2'b01;
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = 1'b1;

  // Pop only from IDLE, so each transaction consumes exactly one word.
  assign word_fifo_rd_en = (state_q == IDLE) && !word_fifo_empty && rst_n;

  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = (state_q == RESP);
  assign busy          = (state_q != IDLE);
  assign wr_count      = wr_count_q;
  assign err_count     = err_count_q;

  // Next-state logic: FSM sequencing, channel handshakes, address and counters.
  always_comb begin
    state_d     = state_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    awaddr_d    = awaddr_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    wr_count_d  = wr_count_q;
    err_count_d = err_count_q;
    case (state_q)
      IDLE: begin
        if (!word_fifo_empty) state_d = LOAD;
      end
      LOAD: begin
        // FIFO read data is valid the cycle after the pop.
        wdata_d   = word_fifo_dout;
        awvalid_d = 1'b1;
        wvalid_d  = 1'b1;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        state_d   = XFER;
      end
      XFER: begin
        // Channels complete independently; done flags remember which finished.
        if (awvalid_q && m_axi_awready) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (wvalid_q && m_axi_wready) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (aw_done_q && w_done_q) state_d = RESP;
      end
      RESP: begin
        if (m_axi_bvalid) begin
          wr_count_d = wr_count_q + 32'd1;
          if ((m_axi_bresp != 2'b00) && (err_count_q != 16'hFFFF)) begin
            err_count_d = err_count_q + 16'd1;
          end
          // Errors are not retried: the address advances regardless.
          if (idx_q == IDX_LAST) begin
            idx_d    = '0;
            awaddr_d = BASE_ADDR;
          end else begin
            idx_d    = idx_q + IDX_W'(1);
            awaddr_d = awaddr_q + ADDR_WIDTH'(16);
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset abandons any in-flight transaction at once.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      awaddr_q    <= BASE_ADDR;
      idx_q       <= '0;
      wdata_q     <= '0;
      wr_count_q  <= 32'd0;
      err_count_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      awaddr_q    <= awaddr_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      wr_count_q  <= wr_count_d;
      err_count_q <= err_count_d;
    end
  end

endmodule

// File: tb/tb_axi_word_writer.sv
// Directed bench for axi_word_writer with a small FIFO model and an AXI slave
// whose ready/valid lines are driven from the stimulus sequence.
module tb_axi_word_writer;

  logic         clk;
  logic         rst_n;
  logic         fifo_empty;
  logic [127:0] fifo_dout;
  logic         rd_en;
  logic [31:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic         awvalid;
  logic         awready;
  logic [127:0] wdata;
  logic [15:0]  wstrb;
  logic         wlast;
  logic         wvalid;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;
  logic         busy;
  logic [31:0]  wr_count;
  logic [15:0]  err_count;

  int n_total = 0;
  int n_bad   = 0;

  axi_word_writer #(
    .DATA_WIDTH  (128),
    .ADDR_WIDTH  (32),
    .BASE_ADDR   (32'h0000_0000),
    .REGION_WORDS(4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .word_fifo_empty(fifo_empty),
    .word_fifo_dout (fifo_dout),
    .word_fifo_rd_en(rd_en),
    .m_axi_awaddr   (awaddr),
    .m_axi_awlen    (awlen),
    .m_axi_awsize   (awsize),
    .m_axi_awburst  (awburst),
    .m_axi_awvalid  (awvalid),
    .m_axi_awready  (awready),
    .m_axi_wdata    (wdata),
    .m_axi_wstrb    (wstrb),
    .m_axi_wlast    (wlast),
    .m_axi_wvalid   (wvalid),
    .m_axi_wready   (wready),
    .m_axi_bresp    (bresp),
    .m_axi_bvalid   (bvalid),
    .m_axi_bready   (bready),
    .busy           (busy),
    .wr_count       (wr_count),
    .err_count      (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // FIFO model: stimulus fills mem/wr_ptr, pops return data one cycle later.
  logic [127:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge clk) begin
    if (rd_en && (wr_ptr != rd_ptr)) begin
      fifo_dout <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  task automatic push(input logic [127:0] w);
    mem[wr_ptr] = w;
    wr_ptr      = wr_ptr + 1;
  endtask

  // Monitor: records beats and pops, checks handshake protocol every cycle.
  logic [31:0]  aw_q [$];
  logic [127:0] w_q [$];
  int pop_cyc [$];
  int av_cyc [$];
  int cyc = 0;
  int pops = 0;
  int err_base = 0;
  bit err_mode = 0;
  bit aw_seen = 0, w_seen = 0;
  bit p_rst = 0, p_aw_hs = 0, p_w_hs = 0, p_awv = 0, p_wv = 0;
  logic [31:0]  p_addr;
  logic [127:0] p_data;
  initial bresp = 2'b00;
  always @(negedge clk) begin
    cyc++;
    if (p_rst) begin
      if (p_aw_hs) chk("aw_drop", awvalid, 0);
      if (p_w_hs) chk("w_drop", wvalid, 0);
      if (p_awv && !p_aw_hs) begin
        chk("aw_hold", awvalid, 1);
        chk("awaddr_hold", awaddr, p_addr);
      end
      if (p_wv && !p_w_hs) begin
        chk("w_hold", wvalid, 1);
        chk("wdata_hold", wdata, p_data);
      end
    end
    if (rd_en) begin
      pops++;
      pop_cyc.push_back(cyc);
      aw_seen = 0;
      w_seen  = 0;
    end
    if (awvalid && !p_awv) av_cyc.push_back(cyc);
    if (awvalid && awready) begin
      aw_q.push_back(awaddr);
      aw_seen = 1;
      bresp = (err_mode && (aw_q.size() - err_base == 2)) ? 2'b10 : 2'b00;
    end
    if (wvalid && wready) begin
      w_q.push_back(wdata);
      w_seen = 1;
    end
    if (bready) chk("bready_after_both", {aw_seen, w_seen}, 2'b11);
    p_rst   = rst_n;
    p_aw_hs = awvalid && awready;
    p_w_hs  = wvalid && wready;
    p_awv   = awvalid;
    p_wv    = wvalid;
    p_addr  = awaddr;
    p_data  = wdata;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (!busy && (wr_ptr == rd_ptr)) begin
        ok = 1;
        break;
      end
    end
    chk("idle_timeout", ok, 1);
    step();
  endtask

  task automatic wait_awv();
    bit ok = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (awvalid) begin
        ok = 1;
        break;
      end
    end
    chk("awvalid_timeout", ok, 1);
  endtask

  int ab, wb, pb, vb, p0;

  initial begin
    rst_n   = 1'b0;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b1;

    // Reset state and tie-offs held during reset.
    step();
    chk("rst_awlen", awlen, 8'd0);
    chk("rst_awsize", awsize, 3'b100);
    chk("rst_awburst", awburst, 2'b01);
    chk("rst_wstrb", wstrb, 16'hFFFF);
    chk("rst_wlast", wlast, 1);
    step();
    rst_n = 1'b1;
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_bready", bready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_awaddr", awaddr, 32'h0);
    chk("rst_wdata", wdata, 128'h0);
    chk("rst_wr_count", wr_count, 32'd0);
    chk("rst_err_count", err_count, 16'd0);

    // Three back-to-back words with every ready held high.
    ab = aw_q.size(); wb = w_q.size(); pb = pop_cyc.size(); vb = av_cyc.size(); p0 = pops;
    awready = 1'b1;
    wready  = 1'b1;
    push(128'h1);
    push(128'h2);
    push(128'h3);
    wait_idle();
    chk("t1_aw_n", aw_q.size() - ab, 3);
    chk("t1_addr0", aw_q[ab], 32'h00);
    chk("t1_addr1", aw_q[ab+1], 32'h10);
    chk("t1_addr2", aw_q[ab+2], 32'h20);
    chk("t1_w_n", w_q.size() - wb, 3);
    chk("t1_data0", w_q[wb], 128'h1);
    chk("t1_data1", w_q[wb+1], 128'h2);
    chk("t1_data2", w_q[wb+2], 128'h3);
    chk("t1_pops", pops - p0, 3);
    chk("t1_wr_count", wr_count, 32'd3);
    chk("t1_busy", busy, 0);
    chk("t1_aw_latency", av_cyc[vb] - pop_cyc[pb], 2);
    chk("t1_pop_gap", pop_cyc[pb+1] - pop_cyc[pb], 5);

    // Channel ordering: W first, then AW first, then both together.
    do_reset();
    ab = aw_q.size(); wb = w_q.size();
    for (int v = 0; v < 3; v++) begin
      awready = 1'b0;
      wready  = 1'b0;
      push(128'hA1 + 128'(v));
      wait_awv();
      if (v == 0) begin
        wready = 1'b1;
        repeat (4) step();
        awready = 1'b1;
      end else if (v == 1) begin
        awready = 1'b1;
        repeat (4) step();
        wready = 1'b1;
      end else begin
        awready = 1'b1;
        wready  = 1'b1;
      end
      wait_idle();
    end
    chk("t2_aw_n", aw_q.size() - ab, 3);
    chk("t2_w_n", w_q.size() - wb, 3);
    chk("t2_addr2", aw_q[ab+2], 32'h20);
    chk("t2_data0", w_q[wb], 128'hA1);
    chk("t2_data1", w_q[wb+1], 128'hA2);
    chk("t2_data2", w_q[wb+2], 128'hA3);
    chk("t2_wr_count", wr_count, 32'd3);

    // Long stall with both readies low and a word still waiting in the FIFO.
    do_reset();
    ab = aw_q.size(); wb = w_q.size();
    awready = 1'b0;
    wready  = 1'b0;
    push(128'hB1);
    push(128'hB2);
    wait_awv();
    p0 = pops;
    repeat (20) step();
    chk("t3_no_pop", pops - p0, 0);
    chk("t3_awvalid", awvalid, 1);
    chk("t3_wvalid", wvalid, 1);
    chk("t3_awaddr", awaddr, 32'h0);
    chk("t3_wdata", wdata, 128'hB1);
    awready = 1'b1;
    wready  = 1'b1;
    wait_idle();
    chk("t3_aw_n", aw_q.size() - ab, 2);
    chk("t3_addr1", aw_q[ab+1], 32'h10);
    chk("t3_data1", w_q[wb+1], 128'hB2);

    // SLVERR on the second of four writes: counted, not retried.
    do_reset();
    ab = aw_q.size();
    err_base = ab;
    err_mode = 1;
    for (int i = 0; i < 4; i++) push(128'hC0 + 128'(i));
    wait_idle();
    err_mode = 0;
    chk("t4_wr_count", wr_count, 32'd4);
    chk("t4_err_count", err_count, 16'd1);
    chk("t4_aw_n", aw_q.size() - ab, 4);
    chk("t4_addr2", aw_q[ab+2], 32'h20);
    chk("t4_addr3", aw_q[ab+3], 32'h30);

    // Region wrap after four words.
    do_reset();
    ab = aw_q.size();
    for (int i = 0; i < 6; i++) push(128'hD0 + 128'(i));
    wait_idle();
    chk("t5_aw_n", aw_q.size() - ab, 6);
    chk("t5_addr3", aw_q[ab+3], 32'h30);
    chk("t5_addr4", aw_q[ab+4], 32'h00);
    chk("t5_addr5", aw_q[ab+5], 32'h10);
    chk("t5_wr_count", wr_count, 32'd6);
    chk("t5_awaddr_next", awaddr, 32'h20);

    // Reset pulse in the middle of a transfer.
    ab = aw_q.size(); wb = w_q.size();
    awready = 1'b0;
    wready  = 1'b0;
    push(128'hE1);
    push(128'hE2);
    wait_awv();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("t6_awvalid", awvalid, 0);
    chk("t6_wvalid", wvalid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_awaddr", awaddr, 32'h0);
    chk("t6_wr_count", wr_count, 32'd0);
    chk("t6_err_count", err_count, 16'd0);
    awready = 1'b1;
    wready  = 1'b1;
    wait_idle();
    chk("t6_aw_n", aw_q.size() - ab, 1);
    chk("t6_addr0", aw_q[ab], 32'h0);
    chk("t6_data0", w_q[wb], 128'hE2);
    chk("t6_wr_count_after", wr_count, 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/axi_word_writer.md
Name: axi_word_writer

Overview:
- Downstream of the byte-to-word packer and its 128-bit word FIFO.
- Pops one packed word at a time and issues it as a single-beat AXI4 write to DDR.
- Write addresses are sequential and wrap within a fixed region.
- Tracks completed writes and error responses for status/debug.

Parameters:
- DATA_WIDTH, 128, word and AXI data width in bits (fixed 128 for this build).
- ADDR_WIDTH, 32, AXI address width.
- BASE_ADDR, 32'h0000_0000, first write address; must be 16-byte aligned.
- REGION_WORDS, 65536, words written before the address wraps back to BASE_ADDR; power of two.

Ports:
- clk  in  1  single system clock; all logic on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- word_fifo_empty  in  1  word FIFO empty flag.
- word_fifo_dout  in  128  word FIFO read data; valid the cycle after word_fifo_rd_en.
- word_fifo_rd_en  out  1  word FIFO pop strobe.
- m_axi_awaddr  out  ADDR_WIDTH  write address.
- m_axi_awlen  out  8  constant 0 (single beat).
- m_axi_awsize  out  3  constant 3'b100 (16 bytes).
- m_axi_awburst  out  2  constant 2'b01 (INCR).
- m_axi_awvalid  out  1  address valid.
- m_axi_awready  in  1  address ready.
- m_axi_wdata  out  128  write data.
- m_axi_wstrb  out  16  constant all-ones.
- m_axi_wlast  out  1  constant 1.
- m_axi_wvalid  out  1  data valid.
- m_axi_wready  in  1  data ready.
- m_axi_bresp  in  2  write response.
- m_axi_bvalid  in  1  response valid.
- m_axi_bready  out  1  response ready.
- busy  out  1  high in any state other than IDLE.
- wr_count  out  32  completed write responses; wraps modulo 2^32.
- err_count  out  16  responses with bresp != 2'b00; saturates at 16'hFFFF.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state = IDLE; awvalid, wvalid, bready, busy = 0.
  - awaddr = BASE_ADDR; wdata = 0; wr_count = 0; err_count = 0.
  - Reset applied mid-transaction abandons the transaction immediately; no hold-off.
- word_fifo_rd_en is combinational: (state == IDLE) && !word_fifo_empty && rst_n. It is never high in any other state, so there is at most one pop per transaction.
- IDLE:
  - If !word_fifo_empty, pop and go to LOAD.
  - Otherwise stay in IDLE.
- LOAD (one cycle):
  - Register wdata <= word_fifo_dout.
  - Set awvalid = 1 and wvalid = 1, visible next cycle.
  - Go to XFER.
- XFER:
  - AW and W channels are independent.
  - awvalid drops the cycle after awvalid && awready; wvalid likewise on wvalid && wready.
  - Either channel may complete first, or both in the same cycle; internal done flags record completion.
  - Go to RESP once both handshakes are complete, including same-cycle completion.
  - awaddr and wdata are held stable while their valid is high; valid never drops before its ready.
- RESP:
  - bready = 1.
  - On bvalid:
    - wr_count += 1.
    - If bresp != 0, err_count += 1, saturating.
    - Advance awaddr by 16; when the word index reaches REGION_WORDS, awaddr returns to BASE_ADDR.
    - bready = 0; go to IDLE.
- Latency:
  - FIFO non-empty seen in IDLE at cycle N: rd_en high in N, awvalid/wvalid high from N+2.
  - Best case with ready held high: next pop at N+5 (one response per 5 cycles).
- Error responses (SLVERR/DECERR) are counted only; the data is not retried and the address still advances.
- Tie-offs awlen, awsize, awburst, wstrb and wlast are constant, including during reset.

Test Plan:
- FIFO preloaded with 3 words (0x..01, 0x..02, 0x..03), awready/wready/bvalid held high -> 3 writes at addresses 0x0, 0x10, 0x20 with matching wdata; wr_count = 3; one rd_en pulse per word; busy low at the end.
- wready asserted 4 cycles before awready, then the reverse order, then same-cycle -> each valid drops exactly one cycle after its own handshake; bready rises only after both handshakes; no duplicate beats.
- awready/wready held low 20 cycles -> awvalid, wvalid, awaddr and wdata stable throughout; rd_en stays low even though the FIFO is non-empty.
- bresp = 2'b10 on the 2nd of 4 writes -> err_count = 1, wr_count = 4; 3rd write address is 0x20 (no retry).
- REGION_WORDS = 4, 6 words written -> addresses 0x0, 0x10, 0x20, 0x30, 0x0, 0x10.
- rst_n low for 1 cycle during XFER with valids high -> next cycle awvalid = wvalid = 0, state IDLE, awaddr = BASE_ADDR, counters 0; the next FIFO word is written at BASE_ADDR.
